dsam_decoder: RTL and testbench
===============================

Name: dsam_decoder

Overview:
- Inverse of the DSAM encoder. Sits directly downstream of it, at the receive end of the compressed link.
- Takes encoded words {sign, corr} and undoes the XOR decorrelation against the previous corr word. This yields the signed inter-channel difference.
- Then undoes the channel-delta by adding the decoded sample from CHANNELS samples earlier. Output is the original sample stream.
- Streaming with valid qualifiers: one sample per cycle, 2-cycle pipeline.

Parameters:
- DATA_WIDTH, 16, width of encoded and decoded words (sign bit + DATA_WIDTH-1 corr bits).
- CHANNELS, 256, number of interleaved channels, which is also the delta distance; must be >= 2.
- CNTR_WIDTH, $clog2(CHANNELS+1), width of warm-up counter and pointer.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: in carries an encoded word this cycle.
- in, input, DATA_WIDTH: encoded word; [W-1] = sign, [W-2:0] = corr.
- out_valid, output, 1: out carries a decoded sample this cycle.
- out, output, DATA_WIDTH: decoded sample, two's complement, modulo 2^DATA_WIDTH.

Behaviour:
- Encoding model being inverted, for accepted sample n:
  - sub[n] = x[n] - x[n-CHANNELS] (mod 2^W) once warm; otherwise sub[n] = x[n].
  - corr[n] = (sub sign ? ~sub[W-2:0] : sub[W-2:0]) ^ corr[n-1], with corr[-1] = 0.
  - Warm means CHANNELS samples have already been accepted.
- Reset (synchronous): out = 0, out_valid = 0, corr_prev = 0, cnt = 0, ptr = 0, stage-1 valid = 0.
  - Delay-line contents are not cleared; warm gating guarantees stale entries are never used.
- Stage 1, registered, only when in_valid = 1:
  - s = in[W-1]; m = in[W-2:0] ^ corr_prev.
  - sub_r <= {s, s ? ~m : m}.
  - corr_prev <= in[W-2:0].
  - warm_r <= (cnt == CHANNELS).
  - cnt <= cnt + 1 if cnt < CHANNELS; saturates at CHANNELS.
- Stage 1 valid: v1 <= in_valid every cycle. When in_valid = 0, all stage-1 state holds.
- Stage 2, when v1 = 1:
  - hist = delay_line[ptr], combinational read.
  - out <= warm_r ? sub_r + hist : sub_r (W-bit wrap, carry discarded).
  - The same decoded value is written to delay_line[ptr].
  - ptr <= (ptr == CHANNELS-1) ? 0 : ptr + 1.
- Stage 2 valid: out_valid <= v1.
- Read-before-write: hist is the value written CHANNELS accepted samples earlier to the same slot. The same-cycle write must not be forwarded to the read.
- Latency: in_valid at cycle t gives out_valid at t+2. Full throughput, no backpressure.
- Bubbles: when in_valid = 0, out_valid drops 2 cycles later and out holds its last value. Bubbles do not advance cnt, ptr or corr_prev.
- Warm-up: the first CHANNELS outputs equal sub directly. Output CHANNELS+1 onward adds history.
- Mid-stream reset: the pipeline is flushed. The next accepted word is treated as sample 0 (corr_prev = 0, not warm). A word presented with reset asserted is discarded.
- Width rules:
  - All arithmetic is unsigned modulo 2^W.
  - The sign bit passes through the XOR stage unchanged; only the corr bits are XORed.

Decomposition:
- Shared package dsam_pkg holds the DATA_WIDTH default, the CHANNELS default, and a function computing CNTR_WIDTH.
- Encoder and decoder both import dsam_pkg.
- One sub-module, dsam_delay_line:
  - CHANNELS x DATA_WIDTH register array.
  - Synchronous write (we, waddr, wdata); combinational read (raddr -> rdata).
  - Internally owns no pointer; ptr logic stays in dsam_decoder.
  - Reused later by an encoder rework.

Test Plan:
- Decorrelation, CHANNELS=4, after reset:
  - Input 0x0005 -> out 0x0005 two cycles later.
  - Next input 0x0005 -> out 0x0000 (m = 5^5 = 0).
- Negative difference, after reset: input 0x8001 -> m = 0x0001, sub = 0xFFFE, out = 0xFFFE.
- Channel delta with wrap, CHANNELS=4:
  - Encode x = 0xFFF0, 0x0001, 0x0002, 0x0003, then 0x0010 (sub = 0x0020) with the reference encoder model.
  - Decoder out sequence reproduces x exactly, including 0x0010 at sample 4.
- Bubbles: same stream with in_valid toggled randomly (about 50%):
  - Decoded values identical to the no-bubble run.
  - out_valid count equals accepted count.
  - Each output appears exactly 2 cycles after its input.
- Mid-stream reset, CHANNELS=4:
  - Reset asserted for one cycle after sample 6 -> out_valid = 0 for two cycles.
  - Next input 0x0007 -> out 0x0007, no history added, corr_prev = 0.
- Round trip: encoder model -> decoder, CHANNELS=256, 2000 random 16-bit samples, including 0x7FFF/0x8000 extremes -> bit-exact match with the original stream.

Source files
------------

// File: rtl/dsam_pkg.sv
// Shared DSAM definitions: default word width, default channel count and
// the warm-up counter width helper used by both encoder and decoder.
package dsam_pkg;

   localparam int DSAM_DATA_WIDTH = 16;
   localparam int DSAM_CHANNELS   = 256;

   // Counter must be able to hold CHANNELS itself, where it saturates once warm.
   function automatic int dsam_cntr_width(input int channels);
      return $clog2(channels + 1);
   endfunction

endpackage

// File: rtl/dsam_delay_line.sv
// CHANNELS-deep history store: synchronous write, combinational read.
// Holds no pointer of its own so the owner decides the addressing scheme.
module dsam_delay_line
   import dsam_pkg::*;
#(
   parameter int DATA_WIDTH = DSAM_DATA_WIDTH,
   parameter int DEPTH      = DSAM_CHANNELS,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents are never cleared; the consumer only reads slots it has written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dsam_decoder.sv
// DSAM receive-side decoder: undoes the XOR decorrelation, then the
// channel delta, in a two-stage streaming pipeline.
module dsam_decoder
   import dsam_pkg::*;
#(
   parameter int DATA_WIDTH = DSAM_DATA_WIDTH,
   parameter int CHANNELS   = DSAM_CHANNELS,
   parameter int CNTR_WIDTH = dsam_cntr_width(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out
);

   localparam int ADDR_WIDTH = $clog2(CHANNELS);

   logic                  sign;
   logic [DATA_WIDTH-2:0] mag;
   logic [DATA_WIDTH-2:0] corr_prev;
   logic [CNTR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] sub_r;
   logic                  warm_r;
   logic                  v1;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0] hist;
   logic [DATA_WIDTH-1:0] dec;
   logic                  hist_we;

   assign sign = in[DATA_WIDTH-1];
   assign mag  = in[DATA_WIDTH-2:0] ^ corr_prev;

   // Stage 1: recover the signed difference; bubbles leave all state untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         corr_prev <= '0;
         cnt       <= '0;
         v1        <= 1'b0;
         sub_r     <= '0;
         warm_r    <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            sub_r     <= {sign, sign ? ~mag : mag};
            corr_prev <= in[DATA_WIDTH-2:0];
            warm_r    <= (cnt == CNTR_WIDTH'(CHANNELS));
            if (cnt < CNTR_WIDTH'(CHANNELS)) begin
               cnt <= cnt + CNTR_WIDTH'(1);
            end
         end
      end
   end

   // The slot read this cycle is the same slot being overwritten, so the
   // read returns the value from CHANNELS accepted samples ago.
   assign dec     = warm_r ? sub_r + hist : sub_r;
   assign hist_we = v1 && !reset;

   dsam_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (CHANNELS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_delay_line (
      .clk   (clk),
      .we    (hist_we),
      .waddr (ptr),
      .wdata (dec),
      .raddr (ptr),
      .rdata (hist)
   );

   // Stage 2: add back the channel history and advance the ring pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else begin
         out_valid <= v1;
         if (v1) begin
            out <= dec;
            ptr <= (ptr == ADDR_WIDTH'(CHANNELS - 1)) ? '0 : ptr + ADDR_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_dsam_decoder.sv
// Directed bench for dsam_decoder: one 4-channel instance for the small
// scenarios and a 256-channel instance for the long round trip.
module tb_dsam_decoder;

   logic        clk;
   logic        reset;
   logic        v4;
   logic [15:0] i4;
   logic        ov4;
   logic [15:0] o4;
   logic        v256;
   logic [15:0] i256;
   logic        ov256;
   logic [15:0] o256;

   int n_tests;
   int n_fail;

   // Reference encoder state (the transmit side being inverted).
   logic [15:0] enc_hist [256];
   int          enc_cnt;
   int          enc_ptr;
   logic [14:0] enc_corr;

   dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (v4),
      .in        (i4),
      .out_valid (ov4),
      .out       (o4)
   );

   dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(256)) dut256 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (v256),
      .in        (i256),
      .out_valid (ov256),
      .out       (o256)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic enc_reset;
      enc_cnt  = 0;
      enc_ptr  = 0;
      enc_corr = '0;
   endtask

   task automatic enc(input int ch, input logic [15:0] x, output logic [15:0] w);
      logic [15:0] sub;
      sub = (enc_cnt >= ch) ? x - enc_hist[enc_ptr] : x;
      enc_hist[enc_ptr] = x;
      enc_ptr = (enc_ptr + 1) % ch;
      if (enc_cnt < ch) enc_cnt++;
      w = {sub[15], (sub[15] ? ~sub[14:0] : sub[14:0]) ^ enc_corr};
      enc_corr = w[14:0];
   endtask

   task automatic tick4(input logic v, input logic [15:0] w);
      v4 = v;
      i4 = w;
      @(negedge clk);
   endtask

   task automatic tick256(input logic v, input logic [15:0] w);
      v256 = v;
      i256 = w;
      @(negedge clk);
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      v4 = 1'b0;
      v256 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      enc_reset();
   endtask

   task automatic test_reset;
      apply_reset();
      n_tests++;
      if (ov4 !== 1'b0 || o4 !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL reset_dut4: got valid=%b out=%h, expected valid=0 out=0000", ov4, o4);
      end
      n_tests++;
      if (ov256 !== 1'b0 || o256 !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL reset_dut256: got valid=%b out=%h, expected valid=0 out=0000", ov256, o256);
      end
   endtask

   task automatic test_decorrelation;
      apply_reset();
      tick4(1'b1, 16'h0005);
      tick4(1'b1, 16'h0005);
      n_tests++;
      if (ov4 !== 1'b1 || o4 !== 16'h0005) begin
         n_fail++;
         $display("[TB] FAIL decorr_first: got valid=%b out=%h, expected valid=1 out=0005", ov4, o4);
      end
      tick4(1'b0, 16'h0000);
      n_tests++;
      if (ov4 !== 1'b1 || o4 !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL decorr_second: got valid=%b out=%h, expected valid=1 out=0000", ov4, o4);
      end
      tick4(1'b0, 16'h0000);
      n_tests++;
      if (ov4 !== 1'b0 || o4 !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL decorr_drain: got valid=%b out=%h, expected valid=0 out=0000", ov4, o4);
      end
   endtask

   task automatic test_negative;
      apply_reset();
      tick4(1'b1, 16'h8001);
      tick4(1'b0, 16'h0000);
      n_tests++;
      if (ov4 !== 1'b1 || o4 !== 16'hFFFE) begin
         n_fail++;
         $display("[TB] FAIL negative: got valid=%b out=%h, expected valid=1 out=fffe", ov4, o4);
      end
   endtask

   task automatic test_channel_delta;
      logic [15:0] x [5];
      logic [15:0] w;
      x = '{16'hFFF0, 16'h0001, 16'h0002, 16'h0003, 16'h0010};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            enc(4, x[i], w);
            tick4(1'b1, w);
         end else begin
            tick4(1'b0, 16'h0000);
         end
         if (i > 0) begin
            n_tests++;
            if (ov4 !== 1'b1 || o4 !== x[i-1]) begin
               n_fail++;
               $display("[TB] FAIL delta_sample%0d: got valid=%b out=%h, expected valid=1 out=%h",
                        i - 1, ov4, o4, x[i-1]);
            end
         end
      end
   endtask

   task automatic test_bubbles;
      logic [15:0] x [5];
      logic [15:0] w [5];
      logic        take;
      logic        pv;
      logic [15:0] px;
      logic [15:0] last;
      int          idx;
      int          accepted;
      int          seen;
      x = '{16'hFFF0, 16'h0001, 16'h0002, 16'h0003, 16'h0010};
      apply_reset();
      for (int i = 0; i < 5; i++) enc(4, x[i], w[i]);
      idx = 0; accepted = 0; seen = 0;
      pv = 1'b0; px = '0; last = '0;
      for (int c = 0; c < 200 && (idx < 5 || pv); c++) begin
         take = (idx < 5) && ($urandom_range(0, 1) == 1);
         tick4(take, take ? w[idx] : 16'hDEAD);
         n_tests++;
         if (ov4 !== pv) begin
            n_fail++;
            $display("[TB] FAIL bubble_valid_c%0d: got %b, expected %b", c, ov4, pv);
         end
         if (ov4 === 1'b1) seen++;
         n_tests++;
         if (o4 !== (pv ? px : last)) begin
            n_fail++;
            $display("[TB] FAIL bubble_data_c%0d: got %h, expected %h", c, o4, pv ? px : last);
         end
         if (pv) last = px;
         pv = take;
         if (take) begin
            px = x[idx];
            idx++;
            accepted++;
         end
      end
      n_tests++;
      if (accepted !== 5 || seen !== accepted) begin
         n_fail++;
         $display("[TB] FAIL bubble_counts: got accepted=%0d outputs=%0d, expected 5 and 5", accepted, seen);
      end
   endtask

   task automatic test_mid_reset;
      logic [15:0] w;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         enc(4, 16'(16'h0100 + i * 3), w);
         tick4(1'b1, w);
      end
      reset = 1'b1;
      tick4(1'b1, 16'h1234);
      reset = 1'b0;
      enc_reset();
      n_tests++;
      if (ov4 !== 1'b0 || o4 !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL midreset_flush1: got valid=%b out=%h, expected valid=0 out=0000", ov4, o4);
      end
      enc(4, 16'h0007, w);
      n_tests++;
      if (w !== 16'h0007) begin
         n_fail++;
         $display("[TB] FAIL midreset_word: got %h, expected 0007", w);
      end
      tick4(1'b1, 16'h0007);
      n_tests++;
      if (ov4 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_flush2: got valid=%b, expected valid=0", ov4);
      end
      tick4(1'b0, 16'h0000);
      n_tests++;
      if (ov4 !== 1'b1 || o4 !== 16'h0007) begin
         n_fail++;
         $display("[TB] FAIL midreset_first: got valid=%b out=%h, expected valid=1 out=0007", ov4, o4);
      end
   endtask

   task automatic test_round_trip;
      logic [15:0] x;
      logic [15:0] px;
      logic [15:0] w;
      int          errs;
      apply_reset();
      px = '0;
      errs = 0;
      for (int i = 0; i <= 2000; i++) begin
         if (i < 2000) begin
            if (i % 97 == 5)      x = 16'h7FFF;
            else if (i % 89 == 7) x = 16'h8000;
            else                  x = 16'($urandom);
            enc(256, x, w);
            tick256(1'b1, w);
         end else begin
            tick256(1'b0, 16'h0000);
         end
         if (i > 0) begin
            n_tests++;
            if (ov256 !== 1'b1 || o256 !== px) begin
               n_fail++;
               errs++;
               if (errs <= 10)
                  $display("[TB] FAIL roundtrip_s%0d: got valid=%b out=%h, expected valid=1 out=%h",
                           i - 1, ov256, o256, px);
            end
         end
         px = x;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      v4 = 1'b0;  i4 = '0;
      v256 = 1'b0; i256 = '0;
      @(negedge clk);
      test_reset();
      test_decorrelation();
      test_negative();
      test_channel_delta();
      test_bubbles();
      test_mid_reset();
      test_round_trip();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
